// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : int_ctrl_pkg
//  Brief    : Shared constants for the interrupt controller: register map,
//             handshake state encodings and the fixed vector width.
//  Revision : 1.0  initial release
// ============================================================================
package int_ctrl_pkg;

    // Width of the vector reported to the CPU; fixed regardless of NUM_IRQ
    localparam int VEC_W = 3;

    // Register map (addr input)
    localparam logic [2:0] INT_MASK   = 3'd0;  // rw, 1 = source masked
    localparam logic [2:0] INT_PEND   = 3'd1;  // r, write-1-to-clear (edge only)
    localparam logic [2:0] INT_EDGE   = 3'd2;  // rw, 1 = rising edge, 0 = level
    localparam logic [2:0] INT_STATUS = 3'd3;  // r, {SPUR, int_vec}
    localparam logic [2:0] INT_EOI    = 3'd4;  // w, end of interrupt

    // Request / acknowledge / EOI handshake states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SERV = 2'd2
    } int_state_t;

endpackage : int_ctrl_pkg
`default_nettype wire

// File: rtl/int_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : int_prio_enc
//  Brief    : Combinational fixed-priority encoder. Returns the index of the
//             lowest set bit of the request vector plus a valid flag.
//  Revision : 1.0  initial release
// ============================================================================
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [VEC_W-1:0]   idx,
    output logic               valid
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = VEC_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule : int_prio_enc
`default_nettype wire

// File: rtl/int_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : int_ctrl
//  Brief    : Interrupt controller. Latches up to NUM_IRQ sources as edge or
//             level requests, masks them, picks the lowest eligible index and
//             drives a single request to the CPU using a request / acknowledge
//             / EOI handshake. Source 0 is the timer output.
//  Revision : 1.0  initial release
// ============================================================================
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [2:0]         addr,
    input  logic               we,
    input  logic [31:0]        wd,
    output logic [31:0]        rd_data,
    output logic               int_req,
    input  logic               int_ack,
    output logic [VEC_W-1:0]   int_vec
);

    localparam logic [NUM_IRQ-1:0] c_mask_rst = '1;
    localparam logic [NUM_IRQ-1:0] c_one      = NUM_IRQ'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] r_mask;
    logic [NUM_IRQ-1:0] r_edge;
    logic [NUM_IRQ-1:0] r_pend;
    logic [NUM_IRQ-1:0] r_prev;
    logic               r_spur;
    int_state_t         r_state;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] w_eligible;
    logic [VEC_W-1:0]   w_sel;
    logic               w_any;
    logic               w_wr_mask;
    logic               w_wr_edge;
    logic               w_wr_pend;
    logic               w_wr_eoi;
    logic               w_accept;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_w1c;
    logic [NUM_IRQ-1:0] w_acc_clr;
    logic [NUM_IRQ-1:0] w_pend_nxt;
    logic               w_unused_wd;

    assign w_eligible = r_pend & ~r_mask;

    int_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio_enc (
        .req   (w_eligible),
        .idx   (w_sel),
        .valid (w_any)
    );

    assign w_wr_mask = we && (addr == INT_MASK);
    assign w_wr_edge = we && (addr == INT_EDGE);
    assign w_wr_pend = we && (addr == INT_PEND);
    assign w_wr_eoi  = we && (addr == INT_EOI);

    // Acceptance only happens on an ack while requesting with something still
    // eligible; an ack that finds nothing eligible is the spurious case.
    assign w_accept  = (r_state == ST_REQ) && int_ack && w_any;

    assign w_rise    = irq_in & ~r_prev;
    assign w_w1c     = w_wr_pend ? wd[NUM_IRQ-1:0] : '0;
    assign w_acc_clr = w_accept ? (c_one << w_sel) : '0;

    // Edge sources: a new rising edge wins over any clear in the same cycle.
    // Level sources simply track the line, so clears have no effect on them.
    assign w_pend_nxt = (r_edge & (w_rise | (r_pend & ~(w_w1c | w_acc_clr))))
                      | (~r_edge & irq_in);

    // Upper write-data bits are not used by any register at this NUM_IRQ
    assign w_unused_wd = ^wd;

    // Register file and request latching
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask <= c_mask_rst;
            r_edge <= '0;
            r_pend <= '0;
            r_prev <= '0;
        end else begin
            r_prev <= irq_in;
            r_pend <= w_pend_nxt;
            if (w_wr_mask) begin
                r_mask <= wd[NUM_IRQ-1:0];
            end
            if (w_wr_edge) begin
                r_edge <= wd[NUM_IRQ-1:0];
            end
        end
    end

    // Handshake FSM with registered int_req / int_vec / SPUR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            int_req <= 1'b0;
            int_vec <= '0;
            r_spur  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state <= ST_REQ;
                        int_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        int_req <= 1'b0;
                        if (w_any) begin
                            int_vec <= w_sel;
                            r_spur  <= 1'b0;
                            r_state <= ST_SERV;
                        end else begin
                            r_spur  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else if (!w_any) begin
                        // Request withdrawn by a mask write or clear
                        int_req <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SERV: begin
                    // No nesting: new events only pend until EOI
                    if (w_wr_eoi) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

    // Register read mux; unused bits and unmapped addresses read zero
    always_comb begin
        rd_data = 32'd0;
        case (addr)
            INT_MASK:   rd_data = {{(32-NUM_IRQ){1'b0}}, r_mask};
            INT_PEND:   rd_data = {{(32-NUM_IRQ){1'b0}}, r_pend};
            INT_EDGE:   rd_data = {{(32-NUM_IRQ){1'b0}}, r_edge};
            INT_STATUS: rd_data = {28'd0, r_spur, int_vec};
            default:    rd_data = 32'd0;
        endcase
    end

endmodule : int_ctrl
`default_nettype wire
